cross_bar_core_param: RTL and testbench

- Parametrised successor of the fixed 3-channel/4-bank crossbar core.
- Accepts requests from CH_NUM request channels with valid/ready handshakes, and queues each request in a per-(channel, bank) FIFO.
- Each of BANK_NUM bank HTU ports has a round-robin arbiter among channels, with a grant lock under backpressure.
- Sits between the mcash channel front-ends and the bank hit-test units.

---
 rtl/cross_bar_core_param.sv | 151 +++++++++++++++
 tb/tb_cross_bar_core_param.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_core_param.sv
// cross_bar_core_param: CH_NUM x BANK_NUM request crossbar.
// Per-(channel,bank) FIFOs feed one round-robin arbiter per bank.
module cross_bar_core_param #(
  parameter int CH_NUM     = 3,
  parameter int BANK_NUM   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 28,
  parameter int WBID_W     = 8,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int BS_W = $clog2(BANK_NUM)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CH_NUM-1:0]          ch_req_valid_i,
  output logic [CH_NUM-1:0]          ch_req_ready_o,
  input  logic [CH_NUM*ADDR_W-1:0]   ch_req_addr_i,
  input  logic [CH_NUM*2-1:0]        ch_req_opcode_i,
  input  logic [CH_NUM*WBID_W-1:0]   ch_req_wbid_i,
  output logic [BANK_NUM-1:0]        bank_htu_valid_o,
  input  logic [BANK_NUM-1:0]        bank_htu_ready_i,
  output logic [BANK_NUM*CH_W-1:0]   bank_htu_ch_id_o,
  output logic [BANK_NUM*2-1:0]      bank_htu_opcode_o,
  output logic [BANK_NUM*ADDR_W-1:0] bank_htu_addr_o,
  output logic [BANK_NUM*WBID_W-1:0] bank_htu_wbid_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2 + ADDR_W + WBID_W;

  logic [CH_NUM-1:0][BANK_NUM-1:0] full;
  logic [CH_NUM-1:0][BANK_NUM-1:0] empty;
  logic [CH_NUM-1:0][BANK_NUM-1:0] push;
  logic [CH_NUM-1:0][BANK_NUM-1:0] pop;
  logic [EW-1:0] head [CH_NUM][BANK_NUM];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [BS_W-1:0] bsel;
    logic [EW-1:0]   entry;

    assign bsel  = ch_req_addr_i[c*ADDR_W +: BS_W];
    assign entry = {ch_req_opcode_i[c*2 +: 2],
                    ch_req_addr_i[c*ADDR_W +: ADDR_W],
                    ch_req_wbid_i[c*WBID_W +: WBID_W]};

    // Every FIFO is emptied by reset, so ready is forced high meanwhile.
    assign ch_req_ready_o[c] = rst_i | ~full[c][bsel];

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_fifo
      logic [PW-1:0] wr_q;
      logic [PW-1:0] rd_q;
      logic [EW-1:0] mem_q [FIFO_DEPTH];

      assign empty[c][b] = (wr_q == rd_q);
      assign full[c][b]  = (wr_q[AW] != rd_q[AW]) &&
                           (wr_q[AW-1:0] == rd_q[AW-1:0]);
      assign push[c][b]  = !rst_i && ch_req_valid_i[c] &&
                           !full[c][b] && (bsel == BS_W'(b));
      assign head[c][b]  = mem_q[rd_q[AW-1:0]];

      // Pointer update; reset discards all queued entries.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wr_q <= '0;
          rd_q <= '0;
        end else begin
          if (push[c][b]) wr_q <= wr_q + 1'b1;
          if (pop[c][b])  rd_q <= rd_q + 1'b1;
        end
      end

      // Entry storage, written on an accepted push.
      always_ff @(posedge clk_i) begin
        if (push[c][b]) mem_q[wr_q[AW-1:0]] <= entry;
      end
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [CH_NUM-1:0] req;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   lock_ch_q;
    logic              lock_q;
    logic [CH_W-1:0]   rr;
    logic [CH_W-1:0]   grant;
    logic              hi;
    logic              lo;
    logic              valid;
    logic              hs;
    logic [EW-1:0]     sel;

    // Round-robin pick from ptr upward with wrap; a held lock wins.
    always_comb begin
      rr = ptr_q;
      hi = 1'b0;
      lo = 1'b0;
      for (int c = 0; c < CH_NUM; c++) req[c] = !empty[c][b];
      for (int c = 0; c < CH_NUM; c++) begin
        if (!hi && req[c] && (CH_W'(c) >= ptr_q)) begin
          rr = CH_W'(c);
          hi = 1'b1;
        end
      end
      for (int c = 0; c < CH_NUM; c++) begin
        if (!hi && !lo && req[c]) begin
          rr = CH_W'(c);
          lo = 1'b1;
        end
      end
      grant = lock_q ? lock_ch_q : rr;
    end

    assign valid = |req;
    assign hs    = valid & bank_htu_ready_i[b];

    for (genvar c = 0; c < CH_NUM; c++) begin : g_pop
      assign pop[c][b] = hs && (grant == CH_W'(c));
    end

    // Head of the granted FIFO.
    always_comb begin
      sel = '0;
      for (int c = 0; c < CH_NUM; c++) begin
        if (grant == CH_W'(c)) sel = head[c][b];
      end
    end

    // Arbiter state: advance ptr on handshake, hold grant while stalled.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ptr_q     <= '0;
        lock_q    <= 1'b0;
        lock_ch_q <= '0;
      end else if (hs) begin
        ptr_q  <= (grant == CH_W'(CH_NUM - 1)) ? '0 : grant + 1'b1;
        lock_q <= 1'b0;
      end else if (valid) begin
        lock_q    <= 1'b1;
        lock_ch_q <= grant;
      end
    end

    assign bank_htu_valid_o[b] = valid;
    assign bank_htu_ch_id_o[b*CH_W +: CH_W] = valid ? grant : '0;
    assign bank_htu_opcode_o[b*2 +: 2] = valid ? sel[EW-1 -: 2] : '0;
    assign bank_htu_addr_o[b*ADDR_W +: ADDR_W] =
      valid ? sel[WBID_W +: ADDR_W] : '0;
    assign bank_htu_wbid_o[b*WBID_W +: WBID_W] =
      valid ? sel[WBID_W-1:0] : '0;
  end

endmodule

// File: tb/tb_cross_bar_core_param.sv
// tb_cross_bar_core_param: scoreboard bench for cross_bar_core_param.
// Queue-based reference model plus decoupled output monitor.
module tb_cross_bar_core_param;
  localparam int CH = 3;
  localparam int BK = 4;
  localparam int D  = 2;
  localparam int AW = 28;
  localparam int WW = 8;
  localparam int CW = 2;
  localparam int EW = 2 + AW + WW;

  typedef logic [EW-1:0] ent_t;
  typedef logic [CW+EW-1:0] rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0]    ch_valid = '0;
  logic [CH-1:0]    ch_ready;
  logic [CH*AW-1:0] ch_addr = '0;
  logic [CH*2-1:0]  ch_op = '0;
  logic [CH*WW-1:0] ch_wb = '0;
  logic [BK-1:0]    b_valid;
  logic [BK-1:0]    b_ready = '0;
  logic [BK*CW-1:0] b_ch;
  logic [BK*2-1:0]  b_op;
  logic [BK*AW-1:0] b_addr;
  logic [BK*WW-1:0] b_wb;

  always #5 clk = ~clk;

  cross_bar_core_param dut (
    .clk_i(clk),
    .rst_i(rst),
    .ch_req_valid_i(ch_valid),
    .ch_req_ready_o(ch_ready),
    .ch_req_addr_i(ch_addr),
    .ch_req_opcode_i(ch_op),
    .ch_req_wbid_i(ch_wb),
    .bank_htu_valid_o(b_valid),
    .bank_htu_ready_i(b_ready),
    .bank_htu_ch_id_o(b_ch),
    .bank_htu_opcode_o(b_op),
    .bank_htu_addr_o(b_addr),
    .bank_htu_wbid_o(b_wb)
  );

  int checks = 0;
  int failures = 0;

  ent_t mq [CH*BK][$];
  rec_t exp_q [BK][$];
  int   rr_ptr [BK];
  bit   held [BK];
  int   held_ch [BK];

  logic          nrst;
  logic [CH-1:0] nv;
  logic [AW-1:0] na [CH];
  logic [1:0]    no [CH];
  logic [WW-1:0] nw [CH];
  logic [BK-1:0] nbr;

  function automatic int bk(input logic [AW-1:0] a);
    return int'(a[1:0]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic step();
    bit [CH-1:0] er;
    bit [BK-1:0] ev;
    int pick;
    int c;
    @(posedge clk);
    #1;
    rst = nrst;
    ch_valid = nv;
    b_ready = nbr;
    for (int i = 0; i < CH; i++) begin
      ch_addr[i*AW +: AW] = na[i];
      ch_op[i*2 +: 2] = no[i];
      ch_wb[i*WW +: WW] = nw[i];
    end
    @(negedge clk);
    for (int i = 0; i < CH; i++)
      er[i] = nrst || (mq[i*BK + bk(na[i])].size() < D);
    ev = '0;
    for (int b = 0; b < BK; b++)
      for (int i = 0; i < CH; i++)
        if (mq[i*BK + b].size() != 0) ev[b] = 1'b1;
    chk("ch_ready", 64'(ch_ready), 64'(er));
    chk("bank_valid", 64'(b_valid), 64'(ev));
    if (nrst) begin
      for (int i = 0; i < CH*BK; i++) mq[i].delete();
      for (int b = 0; b < BK; b++) begin
        rr_ptr[b] = 0;
        held[b] = 1'b0;
        held_ch[b] = 0;
      end
      return;
    end
    for (int b = 0; b < BK; b++) begin
      pick = -1;
      if (held[b]) pick = held_ch[b];
      else
        for (int i = 0; i < CH; i++) begin
          c = (rr_ptr[b] + i) % CH;
          if (pick < 0 && mq[c*BK + b].size() != 0) pick = c;
        end
      if (pick >= 0) begin
        if (nbr[b]) begin
          exp_q[b].push_back({CW'(pick), mq[pick*BK + b].pop_front()});
          rr_ptr[b] = (pick + 1) % CH;
          held[b] = 1'b0;
        end else begin
          held[b] = 1'b1;
          held_ch[b] = pick;
        end
      end
    end
    for (int i = 0; i < CH; i++)
      if (nv[i] && er[i])
        mq[i*BK + bk(na[i])].push_back({no[i], na[i], nw[i]});
  endtask

  // Monitor: compare each bank handshake against the scoreboard.
  initial begin
    rec_t got;
    rec_t want;
    rec_t prev [BK];
    bit   stall [BK];
    for (int b = 0; b < BK; b++) stall[b] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      for (int b = 0; b < BK; b++) begin
        got = {b_ch[b*CW +: CW], b_op[b*2 +: 2],
               b_addr[b*AW +: AW], b_wb[b*WW +: WW]};
        if (rst) begin
          stall[b] = 1'b0;
        end else if (!b_valid[b]) begin
          checks++;
          if (got !== '0) begin
            failures++;
            $display("FAIL idle_zero bank=%0d got=%0h want=0", b, got);
          end
          stall[b] = 1'b0;
        end else begin
          if (stall[b]) begin
            checks++;
            if (got !== prev[b]) begin
              failures++;
              $display("FAIL lock_stable bank=%0d got=%0h want=%0h",
                       b, got, prev[b]);
            end
          end
          if (b_ready[b]) begin
            checks++;
            if (exp_q[b].size() == 0) begin
              failures++;
              $display("FAIL extra_hs bank=%0d got=%0h want=none", b, got);
            end else begin
              want = exp_q[b].pop_front();
              if (got !== want) begin
                failures++;
                $display("FAIL hs_data bank=%0d got=%0h want=%0h",
                         b, got, want);
              end
            end
            stall[b] = 1'b0;
          end else begin
            stall[b] = 1'b1;
            prev[b] = got;
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    nv = '0;
    for (int i = 0; i < CH; i++) begin
      na[i] = '0;
      no[i] = '0;
      nw[i] = '0;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    idle_inputs();
    nbr = '0;
    step();
    nrst = 1'b0;
  endtask

  initial begin
    int pct;
    for (int b = 0; b < BK; b++) begin
      rr_ptr[b] = 0;
      held[b] = 1'b0;
      held_ch[b] = 0;
    end
    do_reset();
    do_reset();
    step();
    chk("idle_ready", 64'(ch_ready), 64'h7);
    chk("idle_addr", 64'(b_addr[AW-1:0]), 64'h0);

    na[1] = 28'h0000012;
    no[1] = 2'd3;
    nw[1] = 8'h5a;
    nv = 3'b010;
    nbr = 4'b0100;
    step();
    nv = '0;
    step();
    chk("single_valid", 64'(b_valid), 64'h4);
    chk("single_ch", 64'(b_ch[2*CW +: CW]), 64'd1);
    chk("single_addr", 64'(b_addr[2*AW +: AW]), 64'h12);
    step();
    chk("single_drop", 64'(b_valid), 64'h0);

    do_reset();
    for (int i = 0; i < CH; i++) begin
      na[i] = AW'(i * 16);
      nw[i] = WW'(i);
    end
    nv = '1;
    step();
    for (int i = 0; i < CH; i++) na[i] = AW'(i * 16 + 64);
    step();
    nv = '0;
    nbr = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_order", 64'(b_ch[CW-1:0]), 64'(k % CH));
    end

    do_reset();
    na[0] = 28'h0000033;
    na[2] = 28'h0000047;
    nv = 3'b101;
    nbr = '0;
    step();
    nv = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ch", 64'(b_ch[3*CW +: CW]), 64'd0);
      chk("bp_addr", 64'(b_addr[3*AW +: AW]), 64'h33);
    end
    nbr = 4'b1000;
    step();
    chk("bp_release", 64'(b_ch[3*CW +: CW]), 64'd0);
    step();
    chk("bp_next", 64'(b_ch[3*CW +: CW]), 64'd2);

    do_reset();
    na[0] = 28'h0000001;
    nv = 3'b001;
    step();
    step();
    nv = '0;
    step();
    chk("full_ready", 64'(ch_ready[0]), 64'd0);
    na[0] = 28'h0000000;
    step();
    chk("other_bank_ready", 64'(ch_ready[0]), 64'd1);

    do_reset();
    for (int i = 0; i < CH; i++) na[i] = AW'(2 + 16 * i);
    nv = '1;
    step();
    nv = '0;
    step();
    nrst = 1'b1;
    step();
    nrst = 1'b0;
    step();
    chk("rst_valid", 64'(b_valid), 64'h0);
    chk("rst_ready", 64'(ch_ready), 64'h7);
    nv = 3'b101;
    nbr = 4'b0100;
    step();
    nv = '0;
    step();
    chk("rst_first_grant", 64'(b_ch[2*CW +: CW]), 64'd0);

    for (int k = 0; k < 1500; k++) begin
      pct = (k / 250) % 3 == 0 ? 20 : ((k / 250) % 3 == 1 ? 60 : 95);
      nrst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < CH; i++) begin
        nv[i] = ($urandom_range(0, 1) == 1);
        na[i] = AW'($urandom);
        no[i] = 2'($urandom);
        nw[i] = WW'($urandom);
      end
      for (int b = 0; b < BK; b++)
        nbr[b] = ($urandom_range(0, 99) < pct);
      if (nrst) begin
        nv = '0;
        nbr = '0;
      end
      step();
    end

    nrst = 1'b0;
    idle_inputs();
    nbr = '1;
    repeat (20) step();
    for (int b = 0; b < BK; b++)
      chk("drain_left", 64'(exp_q[b].size()), 64'd0);
    chk("drain_valid", 64'(b_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
